// File: rtl/cfo_phase_acc_pkg.sv
// Shared types and the phase-format helper for the CFO NCO phase accumulator.
// fmt() maps a 32-bit accumulator phase onto the 16-bit CORDIC scaled-radian word.
package cfo_pkg;

  localparam int FMT_ACC_W = 32;
  localparam int FMT_OUT_W = 16;

  // One full turn of the accumulator lands on this CORDIC phase word.
  localparam logic [15:0] PHASE_FULL_CIRCLE = 16'h4000;

  typedef struct packed {
    logic [31:0] fcw;
    logic [31:0] off;
    logic        zero;
  } cfg_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Truncating sign-extension of the top OUT_W-2 bits: full circle -> 0x4000.
  function automatic logic [FMT_OUT_W-1:0] fmt(input logic [FMT_ACC_W-1:0] x);
    return {{2{x[FMT_ACC_W-1]}}, x[FMT_ACC_W-1 -: FMT_OUT_W-2]};
  endfunction

endpackage

// File: rtl/cfo_phase_acc_if.sv
// AXI-Stream config input and phase output of the CFO NCO, bundled as one interface.
// master = config source / phase sink, slave = the phase accumulator.
interface cfo_phase_acc_if;

  logic [63:0] s_axis_cfg_tdata;
  logic        s_axis_cfg_tuser;
  logic        s_axis_cfg_tvalid;
  logic        s_axis_cfg_tready;

  logic [31:0] m_axis_phase_tdata;
  logic        m_axis_phase_tvalid;
  logic        m_axis_phase_tready;
  logic        m_axis_phase_tlast;

  modport master (
    output s_axis_cfg_tdata,
    output s_axis_cfg_tuser,
    output s_axis_cfg_tvalid,
    input  s_axis_cfg_tready,
    input  m_axis_phase_tdata,
    input  m_axis_phase_tvalid,
    output m_axis_phase_tready,
    input  m_axis_phase_tlast
  );

  modport slave (
    input  s_axis_cfg_tdata,
    input  s_axis_cfg_tuser,
    input  s_axis_cfg_tvalid,
    output s_axis_cfg_tready,
    output m_axis_phase_tdata,
    output m_axis_phase_tvalid,
    input  m_axis_phase_tready,
    output m_axis_phase_tlast
  );

endinterface

// File: rtl/cfo_phase_acc.sv
// NCO phase accumulator feeding the CORDIC phase port; frequency/offset updates are
// deferred to frame boundaries so a correction tone never retunes mid-frame.
module cfo_phase_acc
  import cfo_pkg::*;
#(
  parameter int                ACC_W     = 32,
  parameter int                OUT_W     = 16,
  parameter int                FRAME_LEN = 1024,
  parameter logic [ACC_W-1:0]  FCW_RST   = '0
) (
  input  logic             axis_aclk,
  input  logic             axis_aresetn,
  input  logic             enable,
  cfo_phase_acc_if.slave   axis,
  output logic             cfg_pending
);

  localparam int              CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  state_e            r_state;
  state_e            w_state_next;

  logic [ACC_W-1:0]  r_p;
  logic [ACC_W-1:0]  r_fcw;
  logic [ACC_W-1:0]  r_off;
  logic [CNT_W-1:0]  r_cnt;
  cfg_t              r_shadow;
  logic              r_pend;
  logic [OUT_W-1:0]  r_tdata;
  logic              r_tlast;

  cfg_t              w_beat;
  cfg_t              w_src;
  logic              w_tvalid;
  logic              w_hs;
  logic              w_boundary;
  logic              w_apply;
  logic              w_zero;
  logic              w_load;
  logic [ACC_W-1:0]  w_fcw_eff;
  logic [ACC_W-1:0]  w_off_eff;
  logic [ACC_W-1:0]  w_p_next;
  logic [ACC_W-1:0]  w_sum;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [OUT_W-1:0]  w_phase;

  assign w_beat = {axis.s_axis_cfg_tdata[31:0], axis.s_axis_cfg_tdata[63:32],
                   axis.s_axis_cfg_tuser};

  assign w_hs       = w_tvalid && axis.m_axis_phase_tready;
  assign w_boundary = (w_hs && r_tlast) || (r_state == IDLE);
  // A beat arriving on a boundary bypasses the shadow and wins over an older one.
  assign w_apply    = w_boundary && (axis.s_axis_cfg_tvalid || r_pend);
  assign w_src      = axis.s_axis_cfg_tvalid ? w_beat : r_shadow;
  assign w_fcw_eff  = w_apply ? w_src.fcw[ACC_W-1:0] : r_fcw;
  assign w_off_eff  = w_apply ? w_src.off[ACC_W-1:0] : r_off;
  assign w_zero     = w_apply && w_src.zero;

  always_comb begin
    w_p_next   = r_p;
    w_cnt_next = r_cnt;
    if (w_hs) begin
      w_p_next   = r_p + w_fcw_eff;
      w_cnt_next = (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
    end
    if (w_zero) begin
      w_p_next   = '0;
      w_cnt_next = '0;
    end
  end

  assign w_sum = w_p_next + w_off_eff;

  generate
    if (ACC_W == FMT_ACC_W && OUT_W == FMT_OUT_W) begin : g_pkg_fmt
      assign w_phase = fmt(w_sum);
    end else begin : g_gen_fmt
      assign w_phase = {{2{w_sum[ACC_W-1]}}, w_sum[ACC_W-1 -: OUT_W-2]};
    end
  endgenerate

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    w_state_next = enable ? RUN : IDLE;
      RUN:     w_state_next = enable ? RUN : (w_hs ? IDLE : DRAIN);
      DRAIN:   w_state_next = w_hs ? IDLE : DRAIN;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_tvalid = (r_state != IDLE);
    w_load   = (w_state_next == RUN) && ((r_state == IDLE) || w_hs);
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      r_p      <= '0;
      r_fcw    <= FCW_RST;
      r_off    <= '0;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_pend   <= 1'b0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
    end else begin
      r_p   <= w_p_next;
      r_cnt <= w_cnt_next;
      r_fcw <= w_fcw_eff;
      r_off <= w_off_eff;
      if (w_boundary) begin
        r_pend <= 1'b0;
      end else if (axis.s_axis_cfg_tvalid) begin
        r_pend   <= 1'b1;
        r_shadow <= w_beat;
      end
      if (w_load) begin
        r_tdata <= w_phase;
        r_tlast <= (w_cnt_next == CNT_LAST);
      end
    end
  end

  assign axis.s_axis_cfg_tready   = 1'b1;
  assign axis.m_axis_phase_tdata  = {{(32-OUT_W){1'b0}}, r_tdata};
  assign axis.m_axis_phase_tvalid = w_tvalid;
  assign axis.m_axis_phase_tlast  = r_tlast;
  assign cfg_pending              = r_pend;

endmodule

// File: tb/tb_cfo_phase_acc.sv
// Self-checking bench for cfo_phase_acc: directed steps plus random traffic, checked
// each cycle against a transaction-level model of the NCO's frame/config rules.
module tb_cfo_phase_acc;
  import cfo_pkg::*;

  localparam int FL = 8;

  logic clk = 1'b0;
  logic rstn;
  logic en;
  logic pend;

  cfo_phase_acc_if bus ();

  cfo_phase_acc #(
    .ACC_W     (32),
    .OUT_W     (16),
    .FRAME_LEN (FL),
    .FCW_RST   (32'h0000_0000)
  ) dut (
    .axis_aclk    (clk),
    .axis_aresetn (rstn),
    .enable       (en),
    .axis         (bus),
    .cfg_pending  (pend)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_p, m_fcw, m_off, m_sh_fcw, m_sh_off;
  bit          m_sh_zero, m_pend, m_valid, m_last, m_drain;
  logic [15:0] m_data;
  int          m_cnt;
  logic [15:0] q_obs[$];

  function automatic logic [15:0] ref_fmt(input logic [31:0] v);
    int s;
    s = $signed(v) >>> 18;
    return s[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_fcw = 0; m_off = 0; m_cnt = 0;
    m_sh_fcw = 0; m_sh_off = 0; m_sh_zero = 0;
    m_pend = 0; m_valid = 0; m_last = 0; m_drain = 0; m_data = 0;
  endtask

  task automatic model_step(input bit e, input bit cv, input logic [63:0] cd,
                            input bit cu, input bit r);
    bit hs  = m_valid && r;
    bit bnd = (hs && m_last) || !m_valid;
    bit z   = 0;
    bit ld  = 0;
    if (bnd) begin
      if (cv) begin
        m_fcw = cd[31:0]; m_off = cd[63:32]; z = cu;
      end else if (m_pend) begin
        m_fcw = m_sh_fcw; m_off = m_sh_off; z = m_sh_zero;
      end
      m_pend = 0;
    end else if (cv) begin
      m_sh_fcw = cd[31:0]; m_sh_off = cd[63:32]; m_sh_zero = cu; m_pend = 1;
    end
    if (hs) begin
      m_p   = m_p + m_fcw;
      m_cnt = (m_cnt + 1) % FL;
    end
    if (z) begin
      m_p = 0; m_cnt = 0;
    end
    if (!m_valid) begin
      if (e) begin m_valid = 1; m_drain = 0; ld = 1; end
    end else if (hs) begin
      if (m_drain || !e) begin m_valid = 0; m_drain = 0; end
      else ld = 1;
    end else if (!e) begin
      m_drain = 1;
    end
    if (ld) begin
      m_data = ref_fmt(m_p + m_off);
      m_last = (m_cnt == FL - 1);
    end
  endtask

  task automatic check_outputs();
    check("cfg_tready", {31'd0, bus.s_axis_cfg_tready}, 32'd1);
    check("tvalid", {31'd0, bus.m_axis_phase_tvalid}, {31'd0, m_valid});
    check("cfg_pending", {31'd0, pend}, {31'd0, m_pend});
    if (m_valid) begin
      check("tdata", bus.m_axis_phase_tdata, {16'h0000, m_data});
      check("tlast", {31'd0, bus.m_axis_phase_tlast}, {31'd0, m_last});
    end
  endtask

  task automatic step(input bit e, input bit cv, input logic [63:0] cd,
                      input bit cu, input bit r);
    check_outputs();
    en = e;
    bus.s_axis_cfg_tvalid   = cv;
    bus.s_axis_cfg_tdata    = cd;
    bus.s_axis_cfg_tuser    = cu;
    bus.m_axis_phase_tready = r;
    if (bus.m_axis_phase_tvalid && r) q_obs.push_back(bus.m_axis_phase_tdata[15:0]);
    $display("step en=%0d cfg_v=%0d cfg=%h user=%0d rdy=%0d tvalid=%0d tdata=%h tlast=%0d",
             e, cv, cd, cu, r, bus.m_axis_phase_tvalid, bus.m_axis_phase_tdata,
             bus.m_axis_phase_tlast);
    model_step(e, cv, cd, cu, r);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    en   = 1'b0;
    bus.s_axis_cfg_tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
    model_reset();
    check("rst_tvalid", {31'd0, bus.m_axis_phase_tvalid}, 32'd0);
    check("rst_tdata", bus.m_axis_phase_tdata, 32'd0);
    check("rst_tlast", {31'd0, bus.m_axis_phase_tlast}, 32'd0);
    check("rst_pending", {31'd0, pend}, 32'd0);
    rstn = 1'b1;
  endtask

  initial begin
    logic [63:0] cd;
    bit pat[4];
    rstn = 1'b0;
    en   = 1'b0;
    bus.s_axis_cfg_tdata    = '0;
    bus.s_axis_cfg_tuser    = 1'b0;
    bus.s_axis_cfg_tvalid   = 1'b0;
    bus.m_axis_phase_tready = 1'b0;
    @(negedge clk);
    do_reset(3);

    // Ramp with FCW = 1/256 turn: wrap from 0x1FC0 to 0xE000 at sample 128.
    step(0, 1, {32'h0, 32'h0100_0000}, 1, 1);
    q_obs.delete();
    repeat (130) step(1, 0, '0, 0, 1);
    check("t1_count", {31'd0, q_obs.size() >= 129}, 32'd1);
    if (q_obs.size() >= 129) begin
      check("t1_s0", {16'h0, q_obs[0]}, 32'h0000);
      check("t1_s1", {16'h0, q_obs[1]}, 32'h0040);
      check("t1_s2", {16'h0, q_obs[2]}, 32'h0080);
      check("t1_quarter", {16'h0, q_obs[64]}, {16'h0, PHASE_FULL_CIRCLE >> 2});
      check("t1_s127", {16'h0, q_obs[127]}, 32'h1FC0);
      check("t1_s128", {16'h0, q_obs[128]}, 32'hE000);
    end
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 1);

    // Negative FCW applied while idle with accumulator zeroing.
    step(0, 1, {32'h0, 32'hCDBC_09E7}, 1, 0);
    q_obs.delete();
    repeat (4) step(1, 0, '0, 0, 1);
    check("t2_count", {31'd0, q_obs.size() >= 2}, 32'd1);
    if (q_obs.size() >= 2) begin
      check("t2_s0", {16'h0, q_obs[0]}, 32'h0000);
      check("t2_s1", {16'h0, q_obs[1]}, 32'hF36F);
    end

    // Backpressure 1,0,0,1.
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    repeat (6) for (int i = 0; i < 4; i++) step(1, 0, '0, 0, pat[i]);

    // Mid-frame config: held pending until the tlast handshake.
    step(1, 1, {32'h0000_1234, 32'h0200_0000}, 0, 1);
    repeat (20) step(1, 0, '0, 0, 1);

    // Enable dropped under backpressure, then resumed.
    repeat (3) step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 1);
    repeat (2) step(0, 0, '0, 0, 1);
    repeat (10) step(1, 0, '0, 0, 1);

    // Random traffic.
    repeat (400) begin
      cd = {$urandom, $urandom};
      step($urandom_range(0, 19) != 0, $urandom_range(0, 14) == 0, cd,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
    end

    // Reset mid-frame with a valid sample and a pending config.
    repeat (3) step(1, 0, '0, 0, 1);
    step(1, 1, {32'h1111_0000, 32'h0300_0000}, 0, 0);
    step(1, 0, '0, 0, 0);
    do_reset(1);
    repeat (6) step(1, 0, '0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cfo_phase_acc.md
Name: cfo_phase_acc

Overview:
- Programmable NCO phase accumulator that drives the phase-input AXI-Stream port of the CORDIC sin/cos core (cordic_1) used to synthesise the CFO-correction tone.
- Accepts a frequency control word (FCW) and phase offset over an AXI-Stream config port.
- Emits one phase sample per output handshake, in CORDIC scaled-radian format, with backpressure and frame-aligned tlast.
- Config changes apply only at frame boundaries, so a correction tone never changes frequency mid-frame.

Parameters:
- ACC_W, 32, phase accumulator width in bits; full circle = 2^ACC_W.
- OUT_W, 16, CORDIC phase word width (fix16_13 scaled radians).
- FRAME_LEN, 1024, samples per frame; tlast is asserted on the last sample; must be >= 2.
- FCW_RST, 32'h0000_0000, FCW loaded at reset.

Ports:
- axis_aclk  in  1  clock.
- axis_aresetn  in  1  synchronous active-low reset.
- enable  in  1  run request; level-sensitive.
- s_axis_cfg_tdata  in  64  [31:0] FCW (signed), [63:32] phase offset.
- s_axis_cfg_tuser  in  1  1 = zero the accumulator and the frame counter when this config is applied.
- s_axis_cfg_tvalid  in  1  config valid.
- s_axis_cfg_tready  out  1  tied high; every config beat is accepted.
- m_axis_phase_tdata  out  32  [15:0] phase word, [31:16] = 0.
- m_axis_phase_tvalid  out  1  phase sample valid.
- m_axis_phase_tready  in  1  downstream ready (CORDIC ready, or 1 when unused).
- m_axis_phase_tlast  out  1  last sample of frame.
- cfg_pending  out  1  shadow config captured but not yet applied.

Behaviour:
- Clock and reset: one clock, axis_aclk. axis_aresetn is synchronous and active-low.
- Reset values:
  - P (accumulator) = 0, FCW = FCW_RST, OFF = 0, frame count = 0.
  - State = IDLE.
  - m_axis_phase_tvalid = 0, m_axis_phase_tdata = 0, m_axis_phase_tlast = 0, cfg_pending = 0.
  - s_axis_cfg_tready = 1 (combinational constant).
- Format function: fmt(x) = sign-extend of x[ACC_W-1 : ACC_W-OUT_W+2] to OUT_W bits.
  - A full circle maps to 0x4000 (range 0xE000 .. 0x1FFF).
  - Plain truncation, no rounding.
- Accumulator arithmetic: modulo 2^ACC_W; wrap-around is natural and no saturation is applied.
  - Sample n data = fmt(P_n + OFF).
  - On each output handshake, P_{n+1} = P_n + FCW.
- Output stage:
  - Output is registered. tdata and tlast change only when tvalid = 0 or on a handshake (valid && ready).
  - While tvalid = 1 and tready = 0, tdata, tlast and P hold.
- State machine IDLE/RUN/DRAIN:
  - IDLE -> RUN when enable = 1 is sampled at an edge. tvalid rises on that same edge with sample fmt(P + OFF). Latency from enable to first valid is 1 cycle.
  - RUN: each handshake loads the next sample.
  - RUN -> DRAIN when enable = 0 and tvalid = 1 without a handshake. The held sample stays valid (no retraction).
  - DRAIN -> IDLE on handshake; tvalid falls. P keeps its advanced value.
  - RUN -> IDLE directly when enable = 0 coincides with a handshake.
- Frame counter:
  - Increments on each handshake and wraps FRAME_LEN-1 -> 0.
  - tlast = 1 on the sample whose count is FRAME_LEN-1.
- Config capture: any cfg beat (tvalid = 1) writes the shadow registers and sets cfg_pending. A newer beat overwrites an older pending one.
- Config apply, at a "boundary":
  - Boundary = handshake of a tlast sample, or any cycle in IDLE.
  - Shadow -> FCW/OFF and cfg_pending clears.
  - If tuser = 1: P = 0 and count = 0.
  - The sample loaded on that same edge already uses the new values.
- Simultaneous capture and boundary: the arriving beat is applied directly (bypass) and cfg_pending stays 0.
- Reset mid-operation: all state returns to reset values on the next edge. An in-flight sample is dropped.

Decomposition:
- Package cfo_pkg:
  - typedef cfg_t (packed struct: fcw, off, zero).
  - typedef state_e (IDLE/RUN/DRAIN).
  - localparam PHASE_FULL_CIRCLE = 16'h4000.
- Single module; no sub-module needed. A fmt() function lives in the package.

Test Plan:
1. Reset, FCW 0x0100_0000, OFF 0, enable = 1, tready = 1 -> tdata sequence 0x0000, 0x0040, 0x0080, …; sample 127 = 0x1FC0, sample 128 = 0xE000 (wrap).
2. Cfg FCW 0xCDBC_09E7, tuser = 1, applied while IDLE, then enable -> sample 0 = 0x0000, sample 1 = 0xF36F.
3. Backpressure: tready toggled 1,0,0,1 -> tdata/tlast held during the low cycles; no sample skipped or repeated; count stays aligned.
4. FRAME_LEN = 8; a cfg beat mid-frame -> cfg_pending = 1 until the tlast handshake; the next sample uses the new FCW; tlast on every 8th handshake.
5. enable dropped while tready = 0 -> tvalid stays 1 until the handshake, then 0. Re-enabling resumes from the advanced P.
6. axis_aresetn asserted mid-frame with tvalid = 1 -> the next cycle shows tvalid = 0, tdata = 0, count = 0, cfg_pending = 0.
